// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential reads to a synchronous
// instruction memory and buffers {instr, pc} pairs in a DEPTH-entry prefetch FIFO.
module fetch_queue #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic              pop;
    logic              push;
    logic [CNT_W:0]    credit_used;

    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect;

    // Entries held plus the response still coming back, minus the one leaving now.
    assign credit_used = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign imem_req    = !rst && !redirect && (credit_used < (CNT_W+1)'(DEPTH));

    assign imem_addr = fetch_pc;
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 1'b1;
                inflight_pc <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array is reset because the head is visible on out_instr/out_pc
    // even while out_valid is low, and those outputs must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns {24'h0, addr}, so every instruction
// equals its own PC, which makes ordering, gaps and duplicates visible.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for a request appears the next cycle.
    always @(posedge clk) begin
        if (imem_req) imem_data <= {24'h0, imem_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs changed afterwards settle with a further #1.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Pulse reset across one edge and release it mid-cycle: the caller is then in cycle 0.
    task automatic do_reset(input logic ready);
        rst       = 1'b1;
        redirect  = 1'b0;
        out_ready = ready;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        #1;

        // Reset state
        check("rst_req",   32'(imem_req),  32'h0);
        check("rst_addr",  32'(imem_addr), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count),     32'h0);
        check("rst_instr", out_instr,      32'h0);
        check("rst_pc",    32'(out_pc),    32'h0);

        // Startup latency and streaming with out_ready=1
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("c0_req",   32'(imem_req),  32'h1);
        check("c0_addr",  32'(imem_addr), 32'h0);
        check("c0_valid", 32'(out_valid), 32'h0);
        cyc();
        check("c1_valid", 32'(out_valid), 32'h0);
        check("c1_addr",  32'(imem_addr), 32'h1);
        cyc();
        check("c2_valid", 32'(out_valid), 32'h1);
        check("c2_pc",    32'(out_pc),    32'h0);
        check("c2_instr", out_instr,      32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_pc",    32'(out_pc),    32'(i));
            check("stream_instr", out_instr,      32'(i));
        end

        // Fill with out_ready=0, then full-with-pop, then drain
        do_reset(1'b0);
        repeat (4) cyc();
        check("fill_c4_count", 32'(count),    32'h3);
        check("fill_c4_req",   32'(imem_req), 32'h0);
        cyc();
        check("full_count", 32'(count),     32'h4);
        check("full_req",   32'(imem_req),  32'h0);
        check("full_valid", 32'(out_valid), 32'h1);
        check("full_head",  32'(out_pc),    32'h0);
        cyc();
        check("full_hold_count", 32'(count),    32'h4);
        check("full_hold_req",   32'(imem_req), 32'h0);
        cyc();
        out_ready = 1'b1;
        #1;
        check("fullpop_count", 32'(count),     32'h4);
        check("fullpop_req",   32'(imem_req),  32'h1);
        check("fullpop_addr",  32'(imem_addr), 32'h4);
        check("fullpop_pc",    32'(out_pc),    32'h0);
        check("fullpop_instr", out_instr,      32'h0);
        cyc();
        out_ready = 1'b0;
        #1;
        check("after_pop_count", 32'(count),  32'h3);
        check("after_pop_head",  32'(out_pc), 32'h1);
        cyc();
        out_ready = 1'b1;
        #1;
        check("refill_count", 32'(count), 32'h4);
        for (int i = 1; i <= 6; i++) begin
            check("drain_valid", 32'(out_valid), 32'h1);
            check("drain_pc",    32'(out_pc),    32'(i));
            check("drain_instr", out_instr,      32'(i));
            cyc();
        end

        // Redirect with count=3 and a read in flight
        do_reset(1'b0);
        repeat (4) cyc();
        check("pre_redir_count", 32'(count), 32'h3);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("redir_req",   32'(imem_req),  32'h0);
        check("redir_valid", 32'(out_valid), 32'h0);
        cyc();
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("r1_count", 32'(count),     32'h0);
        check("r1_valid", 32'(out_valid), 32'h0);
        check("r1_req",   32'(imem_req),  32'h1);
        check("r1_addr",  32'(imem_addr), 32'h40);
        cyc();
        check("r2_valid", 32'(out_valid), 32'h0);
        cyc();
        check("r3_valid", 32'(out_valid), 32'h1);
        check("r3_pc",    32'(out_pc),    32'h40);
        check("r3_instr", out_instr,      32'h40);
        cyc();
        check("r4_pc",    32'(out_pc),    32'h41);

        // Redirect near the top of the address space: PC wraps FF -> 00
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        #1;
        check("wrap_redir_valid", 32'(out_valid), 32'h0);
        cyc();
        redirect = 1'b0;
        #1;
        check("wrap_r1_addr", 32'(imem_addr), 32'hFE);
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'hFE + 8'(i);
            check("wrap_valid", 32'(out_valid), 32'h1);
            check("wrap_pc",    32'(out_pc),    32'(e));
            check("wrap_instr", out_instr,      {24'h0, e});
            cyc();
        end

        // Asynchronous reset pulse between clock edges while streaming
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_count", 32'(count),     32'h0);
        check("async_addr",  32'(imem_addr), 32'h0);
        check("async_req",   32'(imem_req),  32'h0);
        rst = 1'b0;
        #1;
        check("rel_req",  32'(imem_req),  32'h1);
        check("rel_addr", 32'(imem_addr), 32'h0);
        cyc();
        check("rel_c1_valid", 32'(out_valid), 32'h0);
        cyc();
        check("rel_c2_valid", 32'(out_valid), 32'h1);
        check("rel_c2_pc",    32'(out_pc),    32'h0);
        cyc();
        check("rel_c3_pc",    32'(out_pc),    32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
